// File: rtl/usrt_pkg.sv
// usrt_pkg: shared constants for the single-clock USRT link.
// Holds the receiver and transmitter state encodings and the default frame width.
package usrt_pkg;

    localparam int USRT_DATA_BITS_DEFAULT = 8;

    localparam logic [1:0] s_IDLE      = 2'd0;
    localparam logic [1:0] s_DATA      = 2'd1;
    localparam logic [1:0] s_STOP      = 2'd2;
    localparam logic [1:0] s_WAIT_HIGH = 2'd3;

    localparam logic [1:0] s_TX_IDLE  = 2'd0;
    localparam logic [1:0] s_TX_START = 2'd1;
    localparam logic [1:0] s_TX_DATA  = 2'd2;
    localparam logic [1:0] s_TX_STOP  = 2'd3;

endpackage

// File: rtl/usrt_rx.sv
// usrt_rx: single-clock USRT receiver, one sample per clock, LSB first,
// with a one-entry holding register and valid/ack handshake.
module usrt_rx
    import usrt_pkg::*;
#(
    parameter int DATA_BITS = USRT_DATA_BITS_DEFAULT
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rx_Ack,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_DV,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Busy
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

    logic [1:0]           r_State;
    logic [CW-1:0]        r_Count;
    logic [DATA_BITS-1:0] r_Shift;
    logic [DATA_BITS-1:0] w_Shift_Next;
    logic [DATA_BITS-1:0] r_Byte;
    logic                 r_DV;
    logic                 r_Frame_Err;
    logic                 r_Overrun;

    // New sample enters at the MSB so d0 lands in bit 0 after the last shift.
    always_comb begin
        w_Shift_Next = r_Shift >> 1;
        w_Shift_Next[DATA_BITS-1] = i_Rx_Serial;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State     <= s_WAIT_HIGH;
            r_Count     <= '0;
            r_Shift     <= '0;
            r_Byte      <= '0;
            r_DV        <= 1'b0;
            r_Frame_Err <= 1'b0;
            r_Overrun   <= 1'b0;
        end else begin
            r_Frame_Err <= 1'b0;
            r_Overrun   <= 1'b0;
            if (r_DV && i_Rx_Ack)
                r_DV <= 1'b0;
            case (r_State)
                s_IDLE: begin
                    if (!i_Rx_Serial) begin
                        r_Count <= '0;
                        r_State <= s_DATA;
                    end
                end
                s_DATA: begin
                    r_Shift <= w_Shift_Next;
                    r_Count <= r_Count + CW'(1);
                    if (r_Count == LAST)
                        r_State <= s_STOP;
                end
                s_STOP: begin
                    if (i_Rx_Serial) begin
                        // An ack on this edge frees the register for the new word.
                        if (!r_DV || i_Rx_Ack) begin
                            r_Byte <= r_Shift;
                            r_DV   <= 1'b1;
                        end else begin
                            r_Overrun <= 1'b1;
                        end
                        r_State <= s_IDLE;
                    end else begin
                        r_Frame_Err <= 1'b1;
                        r_State     <= s_WAIT_HIGH;
                    end
                end
                default: begin
                    if (i_Rx_Serial)
                        r_State <= s_IDLE;
                end
            endcase
        end
    end

    assign o_Rx_Byte   = r_Byte;
    assign o_Rx_DV     = r_DV;
    assign o_Frame_Err = r_Frame_Err;
    assign o_Overrun   = r_Overrun;
    assign o_Busy      = (r_State != s_IDLE);

endmodule

// File: tb/tb_usrt_rx.sv
// tb_usrt_rx: directed and randomized frames against a frame-level
// model of the receiver's holding register and error pulses.
module tb_usrt_rx;

    localparam int N = 8;

    logic         i_Clock = 1'b0;
    logic         i_Reset;
    logic         i_Rx_Serial;
    logic         i_Rx_Ack;
    logic [N-1:0] o_Rx_Byte;
    logic         o_Rx_DV;
    logic         o_Frame_Err;
    logic         o_Overrun;
    logic         o_Busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic         m_dv;
    logic [N-1:0] m_byte;
    int           n_fe;
    int           n_ov;

    usrt_rx #(.DATA_BITS(N)) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Rx_Serial (i_Rx_Serial),
        .i_Rx_Ack    (i_Rx_Ack),
        .o_Rx_Byte   (o_Rx_Byte),
        .o_Rx_DV     (o_Rx_DV),
        .o_Frame_Err (o_Frame_Err),
        .o_Overrun   (o_Overrun),
        .o_Busy      (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one line bit for one clock; return just after the sampling edge.
    task automatic drive(input logic b, input logic ack);
        i_Rx_Serial = b;
        i_Rx_Ack    = ack;
        if (ack && m_dv)
            m_dv = 1'b0;
        @(negedge i_Clock);
        i_Rx_Ack = 1'b0;
    endtask

    task automatic chk_quiet(input string tag, input logic busy);
        chk({tag, "_dv"}, 16'(o_Rx_DV), 16'(m_dv));
        chk({tag, "_byte"}, 16'(o_Rx_Byte), 16'(m_byte));
        chk({tag, "_fe"}, 16'(o_Frame_Err), 16'd0);
        chk({tag, "_ov"}, 16'(o_Overrun), 16'd0);
        chk({tag, "_busy"}, 16'(o_Busy), 16'(busy));
    endtask

    task automatic idle(input int n, input logic ack, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, ack && i == 0);
            chk_quiet(tag, 1'b0);
        end
    endtask

    task automatic frame(input logic [N-1:0] d, input logic stop,
                         input logic ack_start, input logic ack_stop,
                         input string tag);
        logic exp_fe;
        logic exp_ov;
        drive(1'b0, ack_start);
        chk_quiet({tag, "_start"}, 1'b1);
        for (int i = 0; i < N; i++) begin
            drive(d[i], 1'b0);
            chk_quiet({tag, "_bit"}, 1'b1);
        end
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        if (stop) begin
            if (!m_dv || ack_stop) begin
                m_byte = d;
                m_dv   = 1'b1;
            end else begin
                exp_ov = 1'b1;
            end
            i_Rx_Serial = 1'b1;
            i_Rx_Ack    = ack_stop;
            @(negedge i_Clock);
            i_Rx_Ack = 1'b0;
        end else begin
            exp_fe = 1'b1;
            drive(1'b0, ack_stop);
        end
        n_fe += int'(exp_fe);
        n_ov += int'(exp_ov);
        chk({tag, "_stop_dv"}, 16'(o_Rx_DV), 16'(m_dv));
        chk({tag, "_stop_byte"}, 16'(o_Rx_Byte), 16'(m_byte));
        chk({tag, "_stop_fe"}, 16'(o_Frame_Err), 16'(exp_fe));
        chk({tag, "_stop_ov"}, 16'(o_Overrun), 16'(exp_ov));
        chk({tag, "_stop_busy"}, 16'(o_Busy), 16'(!stop));
    endtask

    initial begin
        logic [N-1:0] d;
        logic         stop;
        logic         a_start;
        int           gap;

        m_dv        = 1'b0;
        m_byte      = '0;
        n_fe        = 0;
        n_ov        = 0;
        i_Reset     = 1'b1;
        i_Rx_Serial = 1'b1;
        i_Rx_Ack    = 1'b0;
        repeat (2) @(negedge i_Clock);
        chk_quiet("reset", 1'b1);
        i_Reset = 1'b0;
        idle(2, 1'b1, "idle_after_reset");

        frame(8'hA5, 1'b1, 1'b0, 1'b0, "a5");
        drive(1'b1, 1'b1);
        chk_quiet("a5_ack", 1'b0);
        idle(1, 1'b1, "ack_ignored");

        frame(8'h3C, 1'b1, 1'b0, 1'b0, "b2b_3c");
        frame(8'hC3, 1'b1, 1'b1, 1'b0, "b2b_c3");
        idle(1, 1'b1, "b2b_idle");

        frame(8'h11, 1'b1, 1'b0, 1'b0, "ov_11");
        frame(8'h22, 1'b1, 1'b0, 1'b0, "ov_22");
        idle(1, 1'b0, "ov_pulse_end");
        chk("ov_kept_11", 16'(o_Rx_Byte), 16'h0011);
        idle(1, 1'b1, "ov_ack");
        frame(8'h11, 1'b1, 1'b0, 1'b0, "ovack_11");
        frame(8'h22, 1'b1, 1'b0, 1'b1, "ovack_22");
        chk("ovack_byte_22", 16'(o_Rx_Byte), 16'h0022);
        idle(1, 1'b1, "ovack_idle");

        frame(8'h5A, 1'b0, 1'b0, 1'b0, "fe_5a");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0);
            chk_quiet("fe_low", 1'b1);
        end
        idle(1, 1'b0, "fe_high");
        frame(8'h7E, 1'b1, 1'b0, 1'b0, "fe_7e");
        idle(1, 1'b1, "fe_ack");

        drive(1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0);
        #2 i_Reset = 1'b1;
        m_dv   = 1'b0;
        m_byte = '0;
        #1 chk_quiet("mid_reset", 1'b1);
        i_Rx_Serial = 1'b0;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0);
            chk_quiet("post_reset_low", 1'b1);
        end
        idle(1, 1'b0, "post_reset_high");
        frame(8'h81, 1'b1, 1'b0, 1'b0, "rst_81");
        idle(1, 1'b1, "rst_ack");

        for (int k = 0; k < 256; k++) begin
            d       = N'($urandom);
            stop    = ($urandom_range(0, 15) != 0);
            a_start = ($urandom_range(0, 3) != 0);
            frame(d, stop, a_start, $urandom_range(0, 3) == 0, "rnd");
            gap = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            if (gap > 0)
                idle(gap, $urandom_range(0, 1) == 1, "rnd_idle");
        end
        chk("rnd_any_fe", 16'(n_fe > 0), 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/usrt_rx.md
# usrt_rx

Synchronous serial (USRT) receiver: the receive end of the team's single-clock USRT link. It samples the serial line once per `i_Clock` cycle, detects the start bit, and shifts in `DATA_BITS` data bits LSB first. It then checks the stop bit and presents the byte in a one-entry holding register with a valid/ack handshake, reporting framing and overrun errors. Transmitter and receiver share the same clock, so there is no oversampling and no line synchronizer.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame. Range 1..16.

Ports (`name`, direction, width, meaning):
- `i_Clock`, in, 1: sole clock. All logic is on its rising edge.
- `i_Reset`, in, 1: asynchronous, active-high reset.
- `i_Rx_Serial`, in, 1: serial line. Idle is 1.
- `i_Rx_Ack`, in, 1: consumer has taken `o_Rx_Byte`. It only has effect while `o_Rx_DV`=1.
- `o_Rx_Byte`, out, `DATA_BITS`: last good received word. Valid while `o_Rx_DV`=1.
- `o_Rx_DV`, out, 1: holding register full. Level signal, held until acked.
- `o_Frame_Err`, out, 1: one-cycle pulse when a stop bit is sampled as 0.
- `o_Overrun`, out, 1: one-cycle pulse when a good frame is dropped because the holding register was full.
- `o_Busy`, out, 1: high in every state except s_IDLE.

## Operation
Frame on the line, one bit per cycle: start (0), d0..d(N-1), stop (1). Any number of idle 1s follow, including zero.

State machine:
- **s_IDLE**: wait for a start bit.
  - Sample `i_Rx_Serial`. If 0, clear the bit counter and go to s_DATA.
- **s_DATA**: shift in data bits.
  - Each cycle, shift the sample into the MSB of the shift register (right shift), so d0 ends at bit 0.
  - Increment the counter. After the `DATA_BITS`-th sample, go to s_STOP.
- **s_STOP**: check the stop bit.
  - Sample = 1, register empty, or `i_Rx_Ack` high this edge: load `o_Rx_Byte` and set `o_Rx_DV`=1. Go to s_IDLE.
  - Sample = 1, register full, and no ack: discard the new word and keep the old `o_Rx_Byte`. Pulse `o_Overrun`. Go to s_IDLE.
  - Sample = 0: discard the word and pulse `o_Frame_Err`. Go to s_WAIT_HIGH.
- **s_WAIT_HIGH**: re-arm only after the line returns to idle.
  - Go to s_IDLE on the first sample of 1. Lows seen here are never taken as start bits.

Handshake:
- `o_Rx_DV` clears on an edge where `o_Rx_DV`=1 and `i_Rx_Ack`=1.
- Ack and a good stop on the same edge: the old word is consumed, the new word loads, `o_Rx_DV` stays 1, and there is no overrun.
- `i_Rx_Ack` while `o_Rx_DV`=0 is ignored.

Reset, asynchronous:
- State goes to s_WAIT_HIGH, so a reset released mid-frame never mis-frames on a data 0.
- The counter and shift register clear.
- Output reset values: `o_Rx_Byte`=0, `o_Rx_DV`=0, `o_Frame_Err`=0, `o_Overrun`=0, `o_Busy`=1 (s_WAIT_HIGH).
- A partial frame in progress is lost.

Width rule: the bit counter is $clog2(`DATA_BITS`+1) bits wide and never wraps inside a frame.

## Timing
- Start bit sampled at edge E. Data bits are sampled at E+1..E+`DATA_BITS`, stop at E+`DATA_BITS`+1.
- `o_Rx_DV`, `o_Rx_Byte`, `o_Frame_Err` and `o_Overrun` change at edge E+`DATA_BITS`+1. They are visible in the following cycle, which gives `DATA_BITS`+2 cycles latency from the start-bit edge.
- Error pulses are exactly one cycle wide.
- Back-to-back frames:
  - After a good stop, s_IDLE can sample a new start at the very next edge.
  - A full frame every `DATA_BITS`+2 cycles is sustained, provided each word is acked before the next stop edge.
- After a framing error, at least one sampled 1 is required before the next start is recognized.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `usrt_pkg`:
  - state encoding constants `s_IDLE`, `s_DATA`, `s_STOP`, `s_WAIT_HIGH` (2 bits);
  - `USRT_DATA_BITS_DEFAULT` = 8.
  - The transmitter's state constants move into the same package.
- Single module with no sub-module. The shift register, counter, holding register and FSM are inline.

## Test plan
- Reset, then line idle 1, then frame 0,(0xA5 LSB first),1 → `o_Rx_Byte`=0xA5 and `o_Rx_DV`=1 in cycle E+10. Ack one cycle later → `o_Rx_DV`=0 on the next edge.
- Back-to-back frames 0x3C then 0xC3 with zero idle, each acked on the cycle DV rises → both words received, no errors.
- Frame 0x11 left unacked, then frame 0x22 → `o_Overrun` pulses once and `o_Rx_Byte` stays 0x11. Repeat with ack on the 0x22 stop edge → `o_Rx_Byte`=0x22, no overrun.
- Frame 0x5A with stop bit 0, line held 0 for 3 more cycles, then 1, then a good frame 0x7E → `o_Frame_Err` pulses once, no DV for 0x5A, 0x7E received.
- Assert `i_Reset` at data bit 4 of frame 0xFF, release while line=0 → outputs at reset values, no false frame, the next clean frame 0x81 is received.
- Loopback with the team's transmitter on the same clock, 256 random bytes → all match, no error pulses.
